// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// The change-code encoding must match the upstream coin FSM.
package vend_pkg;

    localparam int unsigned CODE_W  = 3;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        CHG_0  = 3'd0,
        CHG_5  = 3'd1,
        CHG_10 = 3'd2,
        CHG_15 = 3'd3,
        CHG_20 = 3'd4
    } change_code_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_VEND     = 3'd1,
        ST_VEND_REL = 3'd2,
        ST_CHG      = 3'd3,
        ST_DROP     = 3'd4,
        ST_DROP_REL = 3'd5,
        ST_FAULT    = 3'd6
    } disp_state_t;

    // Change is counted in nickel units.
    localparam logic [CODE_W-1:0] DIME_UNITS   = 3'd2;
    localparam logic [CODE_W-1:0] NICKEL_UNITS = 3'd1;

    function automatic logic code_is_valid(logic [CODE_W-1:0] raw);
        return raw <= CODE_W'(CHG_20);
    endfunction

    // Out-of-range codes are served as "no change".
    function automatic change_code_t sanitize_code(logic [CODE_W-1:0] raw);
        if (code_is_valid(raw)) begin
            return change_code_t'(raw);
        end
        return CHG_0;
    endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Small sale queue between the coin FSM and the dispenser FSM.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vend_req_fifo
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  change_code_t i_wdata,
    input  logic         i_pop,
    output change_code_t o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    change_code_t  mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = i_pop && !o_empty;
        do_push  = i_push && (!o_full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        o_rdata  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Queues sales from the coin FSM, drives the vend motor, then pays change
// as dimes/nickels over a 4-phase req/ack handshake; timeouts trap into FAULT.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_soda,
    input  logic [CODE_W-1:0]   i_change,
    output logic                o_vend_req,
    input  logic                i_vend_ack,
    output logic                o_drop_req,
    output logic                o_drop_dime,
    input  logic                i_drop_ack,
    output logic                o_busy,
    output logic                o_overflow,
    output logic                o_code_err,
    output logic                o_fault
);

    localparam int unsigned TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYC - 1);

    disp_state_t         state_q, state_d;
    logic [CODE_W-1:0]   units_q, units_d;
    logic                dime_q, dime_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                overflow_q, overflow_d;
    logic                code_err_q, code_err_d;

    change_code_t        fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_c;
    logic                timeout_c;
    logic                wait_state_c;

    vend_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_soda),
        .i_wdata (sanitize_code(i_change)),
        .i_pop   (pop_c),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            units_q    <= '0;
            dime_q     <= 1'b0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            units_q    <= units_d;
            dime_q     <= dime_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            code_err_q <= code_err_d;
        end
    end

    // Next state; an ack on the limit cycle wins over the timeout.
    always_comb begin
        state_d   = state_q;
        units_d   = units_q;
        dime_d    = dime_q;
        pop_c     = 1'b0;
        timeout_c = (timer_q == T_LIMIT);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    units_d = fifo_rdata;
                    state_d = ST_VEND;
                end
            end
            ST_VEND: begin
                if (i_vend_ack)     state_d = ST_VEND_REL;
                else if (timeout_c) state_d = ST_FAULT;
            end
            ST_VEND_REL: begin
                if (!i_vend_ack)    state_d = ST_CHG;
                else if (timeout_c) state_d = ST_FAULT;
            end
            ST_CHG: begin
                if (units_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    dime_d  = (units_q >= DIME_UNITS);
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_drop_ack) begin
                    units_d = units_q - (dime_q ? DIME_UNITS : NICKEL_UNITS);
                    state_d = ST_DROP_REL;
                end else if (timeout_c) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DROP_REL: begin
                if (!i_drop_ack)    state_d = ST_CHG;
                else if (timeout_c) state_d = ST_FAULT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Wait-state timer and sticky flags.
    always_comb begin
        wait_state_c = (state_q == ST_VEND) || (state_q == ST_VEND_REL) ||
                       (state_q == ST_DROP) || (state_q == ST_DROP_REL);
        timer_d      = '0;
        if (wait_state_c && (state_d == state_q)) begin
            timer_d = timer_q + TW'(1);
        end
        overflow_d = overflow_q | (i_soda && fifo_full && !pop_c);
        code_err_d = code_err_q | (i_soda && !code_is_valid(i_change));
    end

    // Outputs decoded from registered state only.
    always_comb begin
        o_vend_req  = (state_q == ST_VEND);
        o_drop_req  = (state_q == ST_DROP);
        o_drop_dime = (state_q == ST_DROP) && dime_q;
        o_fault     = (state_q == ST_FAULT);
        o_busy      = !fifo_empty || (state_q != ST_IDLE);
        o_overflow  = overflow_q;
        o_code_err  = code_err_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (DEPTH=4, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_change_dispenser;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_soda;
    logic [2:0] i_change;
    logic       o_vend_req;
    logic       i_vend_ack;
    logic       o_drop_req;
    logic       o_drop_dime;
    logic       i_drop_ack;
    logic       o_busy;
    logic       o_overflow;
    logic       o_code_err;
    logic       o_fault;

    int n_cmp = 0;
    int n_err = 0;

    change_dispenser #(
        .DEPTH       (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_soda      (i_soda),
        .i_change    (i_change),
        .o_vend_req  (o_vend_req),
        .i_vend_ack  (i_vend_ack),
        .o_drop_req  (o_drop_req),
        .o_drop_dime (o_drop_dime),
        .i_drop_ack  (i_drop_ack),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow),
        .o_code_err  (o_code_err),
        .o_fault     (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sale(input logic [2:0] code);
        i_soda   = 1'b1;
        i_change = code;
        tick();
        i_soda   = 1'b0;
        i_change = 3'd0;
    endtask

    task automatic wait_vend(input string tag);
        int n = 0;
        int d = 0;
        while (o_vend_req !== 1'b1 && n < 60) begin
            tick();
            n++;
            if (o_drop_req === 1'b1) d++;
        end
        chk_n({tag, "_spurious_drop"}, d, 0);
        chk1({tag, "_vend_req"}, o_vend_req, 1'b1);
    endtask

    task automatic serve_drop(input string tag, input logic exp_dime);
        int n = 0;
        while (o_drop_req !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk1({tag, "_drop_req"}, o_drop_req, 1'b1);
        chk1({tag, "_dime"}, o_drop_dime, exp_dime);
        repeat (3) tick();
        chk1({tag, "_dime_stable"}, o_drop_dime, exp_dime);
        i_drop_ack = 1'b1;
        tick();
        chk1({tag, "_drop_rel"}, o_drop_req, 1'b0);
        i_drop_ack = 1'b0;
        tick();
    endtask

    // Vend handshake then the payout implied by the code: dimes first, nickel last.
    task automatic serve_sale(input string tag, input int code);
        int u;
        wait_vend(tag);
        repeat (3) tick();
        i_vend_ack = 1'b1;
        tick();
        chk1({tag, "_vend_rel"}, o_vend_req, 1'b0);
        i_vend_ack = 1'b0;
        tick();
        u = code;
        while (u > 0) begin
            serve_drop(tag, u >= 2);
            u -= (u >= 2) ? 2 : 1;
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int v = 0;
        int d = 0;
        repeat (cycles) begin
            tick();
            if (o_vend_req === 1'b1) v++;
            if (o_drop_req === 1'b1) d++;
        end
        chk_n({tag, "_extra_vend"}, v, 0);
        chk_n({tag, "_extra_drop"}, d, 0);
        chk1({tag, "_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_soda     = 1'b0;
        i_change   = 3'd0;
        i_vend_ack = 1'b0;
        i_drop_ack = 1'b0;
        tick();
        tick();
        chk1("rst_vend_req", o_vend_req, 1'b0);
        chk1("rst_drop_req", o_drop_req, 1'b0);
        chk1("rst_dime", o_drop_dime, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_overflow", o_overflow, 1'b0);
        chk1("rst_code_err", o_code_err, 1'b0);
        chk1("rst_fault", o_fault, 1'b0);
        i_rst_n = 1'b1;
        tick();

        // 20c: latency c+2, then dime, dime
        sale(3'd4);
        chk1("lat_c1_vend", o_vend_req, 1'b0);
        chk1("lat_c1_busy", o_busy, 1'b1);
        tick();
        chk1("lat_c2_vend", o_vend_req, 1'b1);
        serve_sale("c20", 4);
        chk1("c20_chg_busy", o_busy, 1'b1);
        tick();
        chk1("c20_idle_busy", o_busy, 1'b0);
        idle_check("c20_after", 10);

        // 15c, 5c, 0c as separate sales
        sale(3'd3);
        serve_sale("c15", 3);
        idle_check("c15_after", 6);
        sale(3'd1);
        serve_sale("c5", 1);
        idle_check("c5_after", 6);
        sale(3'd0);
        serve_sale("c0", 0);
        idle_check("c0_after", 10);

        // Queue fill with vend ack held low, then one lost sale
        sale(3'd1);
        sale(3'd2);
        sale(3'd0);
        sale(3'd3);
        sale(3'd4);
        chk1("q_full_no_ovf", o_overflow, 1'b0);
        chk1("q_vend_held", o_vend_req, 1'b1);
        sale(3'd2);
        chk1("q_ovf_set", o_overflow, 1'b1);
        serve_sale("q1", 1);
        serve_sale("q2", 2);
        serve_sale("q3", 0);
        serve_sale("q4", 3);
        serve_sale("q5", 4);
        idle_check("q_after", 12);
        chk1("q_ovf_sticky", o_overflow, 1'b1);

        // Vend timeout: FAULT 16 cycles after VEND entry
        sale(3'd0);
        tick();
        chk1("to_vend_entry", o_vend_req, 1'b1);
        repeat (15) tick();
        chk1("to_limit_vend", o_vend_req, 1'b1);
        chk1("to_limit_fault", o_fault, 1'b0);
        tick();
        chk1("to_fault", o_fault, 1'b1);
        chk1("to_vend_low", o_vend_req, 1'b0);
        i_vend_ack = 1'b1;
        repeat (3) tick();
        i_vend_ack = 1'b0;
        chk1("to_vend_stays_low", o_vend_req, 1'b0);
        chk1("to_fault_sticky", o_fault, 1'b1);
        sale(3'd1);
        sale(3'd1);
        sale(3'd1);
        sale(3'd1);
        chk1("fault_q_busy", o_busy, 1'b1);
        tick();
        chk1("fault_q_ovf_pre", o_overflow, 1'b1);
        i_rst_n = 1'b0;
        tick();
        chk1("fault_rst_fault", o_fault, 1'b0);
        chk1("fault_rst_ovf", o_overflow, 1'b0);
        chk1("fault_rst_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        tick();

        // Overflow while faulted: 4 queue, 5th lost
        sale(3'd0);
        tick();
        repeat (16) tick();
        chk1("f2_fault", o_fault, 1'b1);
        sale(3'd1);
        sale(3'd1);
        sale(3'd1);
        sale(3'd1);
        chk1("f2_four_no_ovf", o_overflow, 1'b0);
        sale(3'd1);
        chk1("f2_fifth_ovf", o_overflow, 1'b1);
        chk1("f2_drop_low", o_drop_req, 1'b0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();

        // Invalid code 6: flagged, served as vend only
        sale(3'd6);
        chk1("cerr_set", o_code_err, 1'b1);
        serve_sale("cerr", 0);
        idle_check("cerr_after", 10);
        chk1("cerr_no_ovf", o_overflow, 1'b0);

        // Async reset in the middle of a drop
        sale(3'd2);
        sale(3'd1);
        sale(3'd1);
        wait_vend("mid");
        repeat (3) tick();
        i_vend_ack = 1'b1;
        tick();
        i_vend_ack = 1'b0;
        begin
            int n = 0;
            while (o_drop_req !== 1'b1 && n < 60) begin
                tick();
                n++;
            end
        end
        chk1("mid_drop_req", o_drop_req, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk1("mid_async_drop", o_drop_req, 1'b0);
        chk1("mid_async_busy", o_busy, 1'b0);
        chk1("mid_async_cerr", o_code_err, 1'b0);
        tick();
        i_rst_n = 1'b1;
        idle_check("mid_after", 12);
        chk1("mid_flag_ovf", o_overflow, 1'b0);
        chk1("mid_flag_cerr", o_code_err, 1'b0);
        chk1("mid_flag_fault", o_fault, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending-machine coin FSM.
- Consumes the FSM's single-cycle sale strobe and 3-bit change code, and queues sales in a small FIFO.
- For each sale it drives the soda vend motor, then pays change as dimes/nickels through a 4-phase req/ack handshake to the coin hopper.
- Handshake timeouts trap into a fault state.

Parameters:
- DEPTH, 4, sale FIFO entries; power of 2, ≥2.
- TIMEOUT_CYC, 1000, max cycles spent in any wait state before fault; ≥2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_soda  in  1  sale strobe from coin FSM; one sale per high cycle.
- i_change  in  3  change code, valid when i_soda=1: 0=0c, 1=5c, 2=10c, 3=15c, 4=20c.
- o_vend_req  out  1  soda motor request.
- i_vend_ack  in  1  soda motor acknowledge.
- o_drop_req  out  1  coin hopper request.
- o_drop_dime  out  1  coin select, valid while o_drop_req=1: 1=dime, 0=nickel.
- i_drop_ack  in  1  coin hopper acknowledge.
- o_busy  out  1  FIFO non-empty or FSM not IDLE.
- o_overflow  out  1  sticky: a sale was lost because the FIFO was full.
- o_code_err  out  1  sticky: change code 5–7 was received.
- o_fault  out  1  sticky: handshake timeout occurred.

Behaviour:
- Reset (async, any time, mid-transaction included): FIFO empty, state IDLE, timer 0, all outputs 0; requests drop immediately.
- All outputs are registered or decoded from registered state only; there is no combinational input→output path.
- Push: on each cycle with i_soda=1, write the change code to the FIFO.
  - Codes 5–7 are stored as 0 and set o_code_err.
  - i_change is ignored when i_soda=0.
- Full FIFO: a push is accepted if a pop occurs in the same cycle. Otherwise the push is dropped and o_overflow is set. FIFO contents are unchanged.
- Push and pop in the same cycle with an empty FIFO: no pop; the entry is popped the following cycle (no bypass).
- State machine (disp_state_t):
  - IDLE: if FIFO non-empty, pop, load units u = code (0..4), go to VEND.
  - VEND: o_vend_req=1. On i_vend_ack=1 → VEND_REL.
  - VEND_REL: req=0. On i_vend_ack=0 → CHG.
  - CHG (one cycle, reqs low): if u=0 → IDLE. If u≥2 → DROP with dime=1, else DROP with dime=0. o_drop_dime is registered on entry to DROP.
  - DROP: o_drop_req=1, o_drop_dime held stable. On i_drop_ack=1: u -= 2 (dime) or 1 (nickel), then → DROP_REL.
  - DROP_REL: req=0. On i_drop_ack=0 → CHG.
  - FAULT: all reqs 0, o_fault=1. Remains until reset. Further pushes are still queued up to DEPTH, with overflow flagged as normal.
- Payout per code:
  - 4 → dime, dime
  - 3 → dime, nickel
  - 2 → dime
  - 1 → nickel
  - 0 → vend only
- Latency: i_soda high in cycle c with the block idle and FIFO empty → o_vend_req high from cycle c+2.
- Timer:
  - Counts cycles in VEND, VEND_REL, DROP and DROP_REL.
  - Clears on every state change.
  - Reaching TIMEOUT_CYC-1 without the exit condition → FAULT on the next edge.
  - Width $clog2(TIMEOUT_CYC).
- An ack arriving in the same cycle as the timeout limit takes priority: normal transition, no fault.
- Acks outside their wait states are ignored.
- Sticky flags clear only on reset.

Decomposition:
- vend_pkg:
  - change_code_t enum: CHG_0, CHG_5, CHG_10, CHG_15, CHG_20 = 0..4, matching the coin FSM change encoding.
  - disp_state_t.
  - DIME_UNITS=2, NICKEL_UNITS=1.
- Sub-module vend_req_fifo:
  - Synchronous, DEPTH×3-bit, async-reset pointers.
  - Push/pop with full/empty outputs; accepts a push when full if a pop occurs in the same cycle.
- change_dispenser: top level containing the FSM, timer and flags.

Test Plan:
- i_soda=1, i_change=4 (20c); acks return 3 cycles after each req, 4-phase → vend req rises at c+2, then exactly two drops with dime=1; o_busy falls after final DROP_REL→CHG→IDLE.
- Separate sales with code 3, then code 1, each single-drop ack → sale 3: dime then nickel; sale 1: nickel only; code 0 → vend only, no drop_req.
- With i_vend_ack held 0, push 5 sales back-to-back (DEPTH=4) → first sale popped into VEND, next 4 queued, none lost, o_overflow=0; 6th push → o_overflow=1; releasing acks → exactly 5 vends served in order.
- i_vend_ack never asserted, TIMEOUT_CYC=16 → FAULT 16 cycles after VEND entry; o_fault=1, o_vend_req=0 permanently until reset.
- i_soda=1 with i_change=6 → o_code_err=1; sale served as vend only, no drop.
- Assert i_rst_n=0 mid-DROP (o_drop_req=1) → o_drop_req low immediately (asynchronously); after release: IDLE, FIFO empty, all flags 0.
